arbiter_in_rr: RTL
==================

// Module: arbiter_in_rr
// PURPOSE
//  Parametrised input-side arbiter for the credit-based router. It replaces the fixed 5-port sticky arbiter.
//  Grants one of NUM_REQ LBDR requests per cycle, one-hot.
//  Adds a rotating-priority mode, packet locking (head..tail), and a starvation limit for sticky mode.
//  Sits between the LBDR modules and the output-side allocator of one input port.
// PARAMETERS
//  NUM_REQ   5  number of requesters; bit order N=0,E=1,W=2,S=3,L=4 for the 5-port router
//  MODE      0  0 = sticky: search starts at last grant; 1 = rotate: search starts at last grant + 1
//  LOCK_EN   1  1 = grant held from head flit until tail flit accepted; 0 = re-arbitrate every cycle
//  HOLD_MAX  0  sticky-mode starvation limit in consecutive grant cycles; 0 = disabled
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  req          in   NUM_REQ    requests from LBDR; bit i = requester i
//  tail         in   NUM_REQ    bit i high = requester i's current flit is a tail flit
//  grant        out  NUM_REQ    one-hot grant, combinational from state and req
//  grant_valid  out  1          |grant
//  grant_idx    out  IDX_W      binary index of the granted requester; 0 when !grant_valid
// BEHAVIOUR
//  IDX_W = max(1, $clog2(NUM_REQ)).
//  State registers:
//   - last[IDX_W]: last granted index.
//   - has_last: 0 = IDLE.
//   - locked, lock_idx.
//   - hold_cnt: width $clog2(HOLD_MAX+1), minimum 1.
//  Reset (async, reset=0): has_last=0, last=0, locked=0, hold_cnt=0.
//   - grant, grant_valid and grant_idx are forced to 0 while reset is low.
//  Grant latency: 0 cycles (combinational). State updates on the next rising clk edge.
//  Priority selection when not locked:
//   - IDLE: search starts at index 0.
//   - MODE=0: search starts at last.
//   - MODE=1: search starts at (last+1) mod NUM_REQ.
//   - The first set req bit, searching cyclically upward, wins.
//  Starvation limit (MODE=0, HOLD_MAX>0): if hold_cnt == HOLD_MAX-1 and any other req is set,
//   the search starts at last+1 for that cycle only.
//  Lock (LOCK_EN=1):
//   - Set on a grant to i with tail[i]=0: locked=1, lock_idx=i.
//   - While locked: grant = req[lock_idx] ? onehot(lock_idx) : 0. Other requests are ignored;
//     a dropped req (credit stall) keeps the lock.
//   - Release on the edge where grant[lock_idx] && tail[lock_idx]. The next cycle arbitrates normally.
//   - A single-flit packet (head with tail) never sets the lock.
//   - The starvation limit never preempts a locked packet.
//  On any grant: last <= granted index, has_last <= 1.
//   - hold_cnt increments (saturating) if the index is unchanged, else resets to 0.
//  No grant: last, has_last and hold_cnt hold; grant=0.
//   - has_last never returns to 0 except by reset.
//  req=0 with a stale locked state is legal; it produces no grant and no assertion.
//  Assertions: $onehot0(grant); grant implies req at the granted bit.
//  Reset asserted mid-packet clears the lock immediately; the first grant after release starts at index 0.
//  NUM_REQ=1: grant = req; the lock logic is still honoured.
// STRUCTURE
//  Package arbiter_pkg:
//   - port index constants (PORT_N..PORT_L);
//   - typedef arb_mode_e {ARB_STICKY, ARB_ROTATE};
//   - function onehot_to_idx.
//  Sub-module rr_pick: combinational cyclic first-set finder.
//   - Inputs req and start index; outputs one-hot plus index.
//   - Implemented as a double-width mask trick.
//  Top level: state regs (always_ff), lock/hold next-state logic, output gating.
// TESTING
//  1 MODE=0, LOCK_EN=0, req=5'b00011 held 4 cycles from reset -> grant=00001 every cycle (sticky N).
//  2 MODE=1, LOCK_EN=0, req=5'b10101 held -> grant sequence 00001,00100,10000,00001 (rotating).
//  3 LOCK_EN=1: N head (tail=0), then req=11111 for 3 cycles, tail[0]=1 on cycle 3
//    -> grant=00001 for 3 cycles, then E (00010) in MODE=1.
//  4 Locked on W; req[2] drops for 2 cycles while req[3]=1 -> grant=0 both cycles; W resumes when req[2] returns.
//  5 MODE=0, HOLD_MAX=3, LOCK_EN=0, req=00011 held -> N,N,N,E, then E held up to the limit.
//  6 Reset pulsed low mid-lock -> grant=0 during reset; after release req=10010 -> grant=00010 (starts at N).

Source files
------------

// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
// Shared definitions for the input-side router arbiter:
//   - PORT_N..PORT_L : requester bit positions for the 5-port router
//   - arb_mode_e     : priority search policy (sticky / rotating)
//   - onehot_to_idx  : binary index of a one-hot vector (up to 32 bits)
// -----------------------------------------------------------------------------
package arbiter_pkg;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

    typedef enum logic {
        ARB_STICKY = 1'b0,
        ARB_ROTATE = 1'b1
    } arb_mode_e;

    // OR of the indices of all set bits; exact for one-hot or all-zero input.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage : arbiter_pkg

// File: rtl/arbiter_in_rr_chk.sv
// -----------------------------------------------------------------------------
// arbiter_in_rr_chk
// Property checker bound inside arbiter_in_rr. Observes the grant outputs:
//   - grant is one-hot or zero
//   - a granted bit always has its request set
//   - grant_valid / grant_idx are consistent with grant
// -----------------------------------------------------------------------------
module arbiter_in_rr_chk
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = 3
) (
    input logic               clk,
    input logic               reset,
    input logic [NUM_REQ-1:0] req_i,
    input logic [NUM_REQ-1:0] grant_i,
    input logic               grant_valid_i,
    input logic [IDX_W-1:0]   grant_idx_i
);

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(grant_i));

    a_grant_has_req : assert property (@(posedge clk) disable iff (!reset)
        (grant_i & ~req_i) == '0);

    a_valid_matches : assert property (@(posedge clk) disable iff (!reset)
        grant_valid_i == (|grant_i));

    a_idx_matches : assert property (@(posedge clk) disable iff (!reset)
        onehot_to_idx(32'(grant_i)) == 5'(grant_idx_i));

endmodule : arbiter_in_rr_chk

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational cyclic first-set finder. Starting at start_i and searching
// upward with wrap-around, returns the first set bit of req_i.
//   req_i   [NUM_REQ]  request vector
//   start_i [IDX_W]    first index to examine (must be < NUM_REQ)
//   grant_o [NUM_REQ]  one-hot winner, 0 when no request
//   idx_o   [IDX_W]    binary index of the winner, 0 when no request
//   valid_o            any request present
// -----------------------------------------------------------------------------
module rr_pick
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    localparam logic [IDX_W:0] SUM_N = (IDX_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot_s;
    logic               found_s;
    logic [IDX_W-1:0]   off_s;
    logic [IDX_W:0]     sum_s;
    logic [IDX_W-1:0]   idx_s;

    // Rotate req so start_i lands at bit 0 (double-width shift), find the
    // lowest set bit, then map the offset back to an absolute index.
    always_comb begin
        rot_s   = NUM_REQ'({req_i, req_i} >> start_i);
        found_s = 1'b0;
        off_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                off_s   = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        sum_s = {1'b0, start_i} + {1'b0, off_s};
        if (sum_s >= SUM_N) begin
            idx_s = IDX_W'(sum_s - SUM_N);
        end else begin
            idx_s = IDX_W'(sum_s);
        end
    end

    assign valid_o = found_s;
    assign idx_o   = found_s ? idx_s : '0;
    assign grant_o = found_s ? (NUM_REQ'(1'b1) << idx_s) : '0;

endmodule : rr_pick

// File: rtl/arbiter_in_rr.sv
// -----------------------------------------------------------------------------
// arbiter_in_rr
// Input-side arbiter for one router input port. Picks one LBDR request per
// cycle (combinational, one-hot) with sticky or rotating priority, optional
// packet locking from head to tail flit and an optional sticky-mode
// starvation limit.
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; also forces outputs to 0
//   req          [NUM_REQ] requests, bit i = requester i (N,E,W,S,L)
//   tail         [NUM_REQ] bit i = requester i's current flit is a tail
//   grant        [NUM_REQ] one-hot grant
//   grant_valid  |grant
//   grant_idx    [IDX_W] binary index of the grant, 0 when no grant
// -----------------------------------------------------------------------------
module arbiter_in_rr
    import arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = 5,
    parameter  int MODE     = 0,
    parameter  int LOCK_EN  = 1,
    parameter  int HOLD_MAX = 0,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] tail,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int HC_W = (HOLD_MAX > 0 && $clog2(HOLD_MAX + 1) > 1)
                          ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HC_W-1:0]  HOLD_SAT = '1;
    localparam logic [HC_W-1:0]  HOLD_LIM = HC_W'(HOLD_MAX - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam arb_mode_e        MODE_E   = (MODE == 1) ? ARB_ROTATE : ARB_STICKY;

    logic [IDX_W-1:0]   last_q,     last_d;
    logic               has_last_q, has_last_d;
    logic               locked_q,   locked_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0]   last_inc_s;
    logic [NUM_REQ-1:0] last_oh_s;
    logic [NUM_REQ-1:0] lock_oh_s;
    logic               starve_s;
    logic [IDX_W-1:0]   start_s;
    logic [NUM_REQ-1:0] pick_grant_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic [NUM_REQ-1:0] grant_raw_s;
    logic [IDX_W-1:0]   gidx_s;

    assign last_inc_s = (last_q == LAST_IDX) ? '0 : last_q + IDX_W'(1);
    assign last_oh_s  = NUM_REQ'(1'b1) << last_q;
    assign lock_oh_s  = NUM_REQ'(1'b1) << lock_idx_q;

    // Sticky holder has used its allowance and someone else is waiting:
    // skip past it for this one cycle.
    assign starve_s = (MODE_E == ARB_STICKY) && (HOLD_MAX > 0) &&
                      (hold_cnt_q == HOLD_LIM) && (|(req & ~last_oh_s));

    // Search start for the unlocked case.
    always_comb begin
        if (!has_last_q) begin
            start_s = '0;
        end else if ((MODE_E == ARB_ROTATE) || starve_s) begin
            start_s = last_inc_s;
        end else begin
            start_s = last_q;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req),
        .start_i (start_s),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // A locked packet owns the port; a stalled owner yields no grant at all.
    always_comb begin
        if (locked_q) begin
            grant_raw_s = req & lock_oh_s;
            gidx_s      = lock_idx_q;
        end else begin
            grant_raw_s = pick_valid_s ? pick_grant_s : '0;
            gidx_s      = pick_idx_s;
        end
    end

    assign grant       = reset ? grant_raw_s : '0;
    assign grant_valid = |grant;
    assign grant_idx   = grant_valid ? gidx_s : '0;

    // Next-state for priority pointer, hold counter and packet lock.
    always_comb begin
        last_d     = last_q;
        has_last_d = has_last_q;
        hold_cnt_d = hold_cnt_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;

        if (grant_valid) begin
            last_d     = gidx_s;
            has_last_d = 1'b1;
            if (has_last_q && (gidx_s == last_q)) begin
                hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q
                                                      : hold_cnt_q + HC_W'(1);
            end else begin
                hold_cnt_d = '0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q;
        end

        if (locked_q) begin
            if (grant_valid && tail[lock_idx_q]) begin
                locked_d = 1'b0;
            end else begin
                locked_d = 1'b1;
            end
        end else if ((LOCK_EN != 0) && grant_valid && !tail[gidx_s]) begin
            locked_d   = 1'b1;
            lock_idx_d = gidx_s;
        end else begin
            locked_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q     <= '0;
            has_last_q <= 1'b0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            has_last_q <= has_last_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    arbiter_in_rr_chk #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req),
        .grant_i       (grant),
        .grant_valid_i (grant_valid),
        .grant_idx_i   (grant_idx)
    );

endmodule : arbiter_in_rr
